// File: rtl/ad9361_rx_stim_gen.sv
// AD9361 receive-interface stimulus source: emits gap-free rx_frame/rx_data word
// streams (1R1T or 2R2T) from counter, PN15, constant or externally fed samples.
module ad9361_rx_stim_gen #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CH     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_enable,
  input  logic [1:0]                     cfg_mode,
  input  logic [CNT_W-1:0]               cfg_burst_len,
  input  logic [DATA_WIDTH-1:0]          cfg_const,
  input  logic [2*NUM_CH*DATA_WIDTH-1:0] s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic                           rx_frame,
  output logic [DATA_WIDTH/2-1:0]        rx_data,
  output logic                           rx_valid,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    underflow_cnt
);
  // Handshake: a frame moves from s_data into the frame register on the clock
  // edge where s_valid && s_ready; s_ready high with s_valid low sends a zero frame.
  localparam int DW      = DATA_WIDTH;
  localparam int HW      = DATA_WIDTH / 2;
  localparam int NCOMP   = 2 * NUM_CH;
  localparam int FW      = 4 * NUM_CH;
  localparam int WI_W    = $clog2(FW);
  localparam int FRAME_W = NCOMP * DW;

  localparam logic [1:0] MODE_CNT   = 2'd0;
  localparam logic [1:0] MODE_PN    = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;
  localparam logic [1:0] MODE_EXT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                en_q, stop_q, done_pend;
  logic [1:0]          mode_q;
  logic [CNT_W-1:0]    burst_q, frames_sent;
  logic [DW-1:0]       const_q, cnt_q;
  logic [14:0]         lfsr_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [WI_W-1:0]     w_q;

  logic                enable_rise, last_word, burst_end, run_ends, load_frame, ext_empty;
  logic [1:0]          mode_eff;
  logic [DW-1:0]       const_eff, cnt_base, cnt_nxt;
  logic [14:0]         lfsr_walk, lfsr_nxt;
  logic [FRAME_W-1:0]  frame_nxt;
  logic [HW-1:0]       word_tab [FW];
  logic                valid_d, frame_d;
  logic [HW-1:0]       data_d;

  assign enable_rise = cfg_enable && !en_q;
  assign last_word   = (w_q == WI_W'(FW - 1));
  assign burst_end   = (burst_q != '0) && ((frames_sent + CNT_W'(1)) == burst_q);
  assign run_ends    = burst_end || stop_q || !cfg_enable;
  assign load_frame  = (state == ARM) || ((state == RUN) && last_word && !run_ends);
  // ARM loads the first frame before the run configuration is latched.
  assign mode_eff    = (state == ARM) ? cfg_mode : mode_q;
  assign const_eff   = (state == ARM) ? cfg_const : const_q;
  assign cnt_base    = (state == ARM) ? '0 : cnt_q;
  assign s_ready     = (mode_eff == MODE_EXT) && load_frame;
  assign ext_empty   = s_ready && !s_valid;
  assign busy        = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable_rise) state_nxt = ARM;
      ARM:     state_nxt = RUN;
      RUN:     if (last_word && run_ends) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next frame contents; the LFSR steps once per component in I0,Q0,I1,Q1 order.
  always_comb begin
    frame_nxt = '0;
    lfsr_walk = (state == ARM) ? 15'h7FFF : lfsr_q;
    for (int k = 0; k < NCOMP; k++) begin
      lfsr_walk = {lfsr_walk[13:0], lfsr_walk[14] ^ lfsr_walk[13]};
      case (mode_eff)
        MODE_CNT:   frame_nxt[k*DW +: DW] = cnt_base + DW'(k);
        MODE_PN:    frame_nxt[k*DW +: DW] = DW'(lfsr_walk);
        MODE_CONST: frame_nxt[k*DW +: DW] = const_eff;
        default:    frame_nxt[k*DW +: DW] = s_valid ? s_data[k*DW +: DW] : '0;
      endcase
    end
    lfsr_nxt = lfsr_walk;
    cnt_nxt  = cnt_base + DW'(NCOMP);
  end

  // Word order per channel: I_hi, Q_hi, I_lo, Q_lo.
  for (genvar gw = 0; gw < FW; gw++) begin : g_word
    localparam int COMP = 2 * (gw / 4) + (gw % 2);
    localparam int OFS  = COMP * DW + (((gw % 4) < 2) ? HW : 0);
    assign word_tab[gw] = frame_q[OFS +: HW];
  end

  // Output logic
  always_comb begin
    valid_d = 1'b0;
    frame_d = 1'b0;
    data_d  = '0;
    if (state == RUN) begin
      valid_d = 1'b1;
      frame_d = (w_q < WI_W'(NCOMP));
      data_d  = word_tab[w_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q          <= 1'b0;
      stop_q        <= 1'b0;
      done_pend     <= 1'b0;
      mode_q        <= '0;
      burst_q       <= '0;
      const_q       <= '0;
      cnt_q         <= '0;
      lfsr_q        <= 15'h7FFF;
      frame_q       <= '0;
      w_q           <= '0;
      frames_sent   <= '0;
      underflow_cnt <= '0;
    end else begin
      en_q      <= cfg_enable;
      done_pend <= (state == RUN) && last_word && burst_end;
      if (state == ARM) begin
        mode_q      <= cfg_mode;
        burst_q     <= cfg_burst_len;
        const_q     <= cfg_const;
        w_q         <= '0;
        frames_sent <= '0;
        stop_q      <= 1'b0;
      end else if (state == RUN) begin
        w_q <= last_word ? '0 : w_q + WI_W'(1);
        // A dropped enable is remembered so the frame finishes even if it returns.
        if (!cfg_enable) stop_q <= 1'b1;
        if (last_word) frames_sent <= frames_sent + CNT_W'(1);
      end
      if (load_frame) begin
        frame_q <= frame_nxt;
        cnt_q   <= cnt_nxt;
        lfsr_q  <= lfsr_nxt;
      end
      if (state == ARM)
        underflow_cnt <= ext_empty ? 16'd1 : 16'd0;
      else if (ext_empty && (underflow_cnt != 16'hFFFF))
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_frame <= 1'b0;
      rx_data  <= '0;
      done     <= 1'b0;
    end else begin
      rx_valid <= valid_d;
      rx_frame <= frame_d;
      rx_data  <= data_d;
      done     <= done_pend;
    end
  end

endmodule

// File: tb/tb_ad9361_rx_stim_gen.sv
// Bench for ad9361_rx_stim_gen: a 1R1T and a 2R2T instance checked against a
// frame-level model of the word stream.
module tb_ad9361_rx_stim_gen;
  localparam int DW = 12;
  localparam int HW = 6;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic              en1, en2;
  logic [1:0]        cfg_mode;
  logic [15:0]       cfg_burst_len;
  logic [DW-1:0]     cfg_const;
  logic [2*DW-1:0]   s_data1;
  logic              s_valid1;
  logic [4*DW-1:0]   s_data2;
  logic              s_valid2;
  logic              s_ready1, rx_frame1, rx_valid1, busy1, done1;
  logic              s_ready2, rx_frame2, rx_valid2, busy2, done2;
  logic [HW-1:0]     rx_data1, rx_data2;
  logic [15:0]       uf1, uf2;

  ad9361_rx_stim_gen #(.DATA_WIDTH(DW), .NUM_CH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_enable(en1), .cfg_mode(cfg_mode),
    .cfg_burst_len(cfg_burst_len), .cfg_const(cfg_const), .s_data(s_data1),
    .s_valid(s_valid1), .s_ready(s_ready1), .rx_frame(rx_frame1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .busy(busy1), .done(done1), .underflow_cnt(uf1)
  );

  ad9361_rx_stim_gen #(.DATA_WIDTH(DW), .NUM_CH(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .cfg_enable(en2), .cfg_mode(cfg_mode),
    .cfg_burst_len(cfg_burst_len), .cfg_const(cfg_const), .s_data(s_data2),
    .s_valid(s_valid2), .s_ready(s_ready2), .rx_frame(rx_frame2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .busy(busy2), .done(done2), .underflow_cnt(uf2)
  );

  int sel;
  logic          o_valid, o_frame, o_busy, o_done, o_ready;
  logic [HW-1:0] o_data;
  logic [15:0]   o_uf;
  assign o_valid = (sel == 2) ? rx_valid2 : rx_valid1;
  assign o_frame = (sel == 2) ? rx_frame2 : rx_frame1;
  assign o_data  = (sel == 2) ? rx_data2  : rx_data1;
  assign o_busy  = (sel == 2) ? busy2     : busy1;
  assign o_done  = (sel == 2) ? done2     : done1;
  assign o_ready = (sel == 2) ? s_ready2  : s_ready1;
  assign o_uf    = (sel == 2) ? uf2       : uf1;

  // Scoreboard: expected {rx_frame, rx_data} per word
  logic [HW:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int word_no = 0;
  int unsigned model_cnt;
  int unsigned model_lfsr;

  // Reference model: frame of 2*nc components -> 4*nc bus words
  function automatic void push_frame(input int nc, input int unsigned comps[4]);
    int unsigned w[4];
    for (int c = 0; c < nc; c++) begin
      w[0] = comps[2*c] >> 6;
      w[1] = comps[2*c+1] >> 6;
      w[2] = comps[2*c] % 64;
      w[3] = comps[2*c+1] % 64;
      for (int s = 0; s < 4; s++)
        exp_q.push_back({1'((4*c + s) < 2*nc), HW'(w[s])});
    end
  endfunction

  function automatic void push_counter_frame(input int nc);
    int unsigned comps[4];
    for (int k = 0; k < 4; k++) comps[k] = (model_cnt + k) % 4096;
    model_cnt = (model_cnt + 2*nc) % 4096;
    push_frame(nc, comps);
  endfunction

  function automatic void push_pn_frame(input int nc);
    int unsigned comps[4];
    for (int k = 0; k < 4; k++) comps[k] = 0;
    for (int k = 0; k < 2*nc; k++) begin
      model_lfsr = ((model_lfsr * 2) % 32768) + (((model_lfsr >> 14) ^ (model_lfsr >> 13)) % 2);
      comps[k] = model_lfsr % 4096;
    end
    push_frame(nc, comps);
  endfunction

  function automatic void push_const_frame(input int nc, input int unsigned v);
    int unsigned comps[4];
    for (int k = 0; k < 4; k++) comps[k] = v;
    push_frame(nc, comps);
  endfunction

  // Driver tasks (called at a negedge)
  task automatic arm(input int which);
    sel = which;
    if (which == 2) en2 = 1'b1; else en1 = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL arm_cycle: busy=%0b valid=%0b, expected busy=1 valid=0", o_busy, o_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL arm_latency: valid=%0b one cycle early, expected 0", o_valid);
    end
    @(posedge clk); @(negedge clk);
    word_no = 0;
  endtask

  task automatic check_stream(input int n);
    logic [HW:0] e;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_model_empty at word %0d", word_no);
      end else begin
        e = exp_q.pop_front();
        if ({o_valid, o_frame, o_data} !== {1'b1, e}) begin
          errors++;
          $display("FAIL stream word %0d: got valid=%0b frame=%0b data=%h, expected valid=1 frame=%0b data=%h",
                   word_no, o_valid, o_frame, o_data, e[HW], e[HW-1:0]);
        end
      end
      word_no++;
      @(negedge clk);
    end
  endtask

  task automatic check_idle_after(input int cycles, input int exp_done);
    int done_seen;
    done_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      checks++;
      if (o_valid !== 1'b0 || o_frame !== 1'b0 || o_data !== '0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: valid=%0b frame=%0b data=%h busy=%0b, expected all 0",
                 i, o_valid, o_frame, o_data, o_busy);
      end
      if (o_done === 1'b1) done_seen++;
      if (i == 0 && exp_done != 0) begin
        checks++;
        if (o_done !== 1'b1) begin
          errors++;
          $display("FAIL done_timing: done=%0b after last word, expected 1", o_done);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (done_seen != exp_done) begin
      errors++;
      $display("FAIL done_count: saw %0d pulses, expected %0d", done_seen, exp_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_leftover: %0d words never emitted, expected 0", exp_q.size());
    end
  endtask

  // Tests
  task automatic test_reset();
    checks++;
    if ({s_ready1, rx_frame1, rx_data1, rx_valid1, busy1, done1, uf1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: outputs=%h, expected 0",
               {s_ready1, rx_frame1, rx_data1, rx_valid1, busy1, done1, uf1});
    end
    checks++;
    if ({s_ready2, rx_frame2, rx_data2, rx_valid2, busy2, done2, uf2} !== '0) begin
      errors++;
      $display("FAIL reset_dut2: outputs=%h, expected 0",
               {s_ready2, rx_frame2, rx_data2, rx_valid2, busy2, done2, uf2});
    end
  endtask

  task automatic test_counter_wrap();
    cfg_mode = 2'd0; cfg_burst_len = 16'd0; model_cnt = 0; exp_q.delete();
    for (int f = 0; f < 2049; f++) push_counter_frame(1);
    arm(1);
    check_stream(2049*4 - 3);
    en1 = 1'b0;
    check_stream(3);
    check_idle_after(10, 0);
  endtask

  task automatic test_burst_2ch();
    cfg_mode = 2'd0; cfg_burst_len = 16'd3; model_cnt = 0; exp_q.delete();
    for (int f = 0; f < 3; f++) push_counter_frame(2);
    arm(2);
    check_stream(24);
    check_idle_after(20, 1);
    en2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_external();
    cfg_mode = 2'd3; cfg_burst_len = 16'd0; s_valid1 = 1'b0; exp_q.delete();
    fork
      begin : drv
        int loads;
        int budget;
        int unsigned comps[4];
        loads = 0;
        budget = 0;
        while (loads < 6 && budget < 200) begin
          @(negedge clk);
          budget++;
          if (s_ready1 === 1'b1) begin
            s_data1 = 24'($urandom());
            s_valid1 = (loads >= 2);
            for (int k = 0; k < 4; k++) comps[k] = 0;
            if (loads >= 2) begin
              comps[0] = s_data1[DW-1:0];
              comps[1] = s_data1[2*DW-1:DW];
            end
            push_frame(1, comps);
            loads++;
          end else begin
            s_valid1 = 1'b0;
          end
        end
        checks++;
        if (loads != 6) begin
          errors++;
          $display("FAIL ext_loads: %0d frames requested, expected 6", loads);
        end
      end
      begin
        arm(1);
        check_stream(21);
        en1 = 1'b0;
        check_stream(3);
      end
    join
    s_valid1 = 1'b0;
    checks++;
    if (o_uf !== 16'd2) begin
      errors++;
      $display("FAIL ext_underflow: underflow_cnt=%0d, expected 2", o_uf);
    end
    check_idle_after(8, 0);
  endtask

  task automatic test_const_random();
    int blen;
    int unsigned cval;
    for (int it = 0; it < 2; it++) begin
      blen = $urandom_range(1, 4);
      cval = $urandom_range(0, 4095);
      cfg_mode = 2'd2; cfg_burst_len = 16'(blen); cfg_const = DW'(cval); exp_q.delete();
      for (int f = 0; f < blen; f++) push_const_frame(2, cval);
      arm(2);
      check_stream(1);
      cfg_mode = 2'd0; cfg_const = ~cfg_const; cfg_burst_len = 16'd0;
      check_stream(blen*8 - 1);
      check_idle_after(10, 1);
      en2 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_pn_reset();
    cfg_mode = 2'd1; cfg_burst_len = 16'd0; model_lfsr = 32'h7FFF; exp_q.delete();
    for (int f = 0; f < 2; f++) push_pn_frame(1);
    arm(1);
    check_stream(2);
    rst = 1'b1;
    en1 = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_frame, o_data, o_valid, o_busy, o_done, o_uf} !== '0) begin
      errors++;
      $display("FAIL rst_midframe: outputs=%h, expected 0",
               {o_ready, o_frame, o_data, o_valid, o_busy, o_done, o_uf});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.delete(); model_lfsr = 32'h7FFF;
    for (int f = 0; f < 3; f++) push_pn_frame(1);
    arm(1);
    checks++;
    if (o_data !== 6'h3F) begin
      errors++;
      $display("FAIL pn_restart_first_i_hi: data=%h, expected 3f", o_data);
    end
    check_stream(12 - 3);
    en1 = 1'b0;
    check_stream(3);
    check_idle_after(6, 0);
  endtask

  initial begin
    rst = 1'b1; sel = 1;
    en1 = 1'b0; en2 = 1'b0;
    cfg_mode = 2'd0; cfg_burst_len = 16'd0; cfg_const = '0;
    s_data1 = '0; s_valid1 = 1'b0; s_data2 = '0; s_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_counter_wrap();
    test_burst_2ch();
    test_external();
    test_const_random();
    test_pn_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the test sequence ended");
    $fatal(1, "time limit");
  end

endmodule
